// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that shares one AXI3 read master (AR/R) between NUM_REQ
// requesters, with one burst in flight and a sticky protocol-error flag.
//
// state | meaning
// IDLE  | no burst in flight; arbitrate and accept one request per cycle
// ADDR  | m_arvalid high, holding m_ar* until the master accepts
// DATA  | R beats pass straight through to the granted requester until m_rlast
module axi_rd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 6
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [NUM_REQ-1:0]              s_arvalid,
    output logic [NUM_REQ-1:0]              s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]       s_araddr,
    input  logic [NUM_REQ*4-1:0]            s_arlen,
    input  logic [NUM_REQ*(ID_W-IDX_W)-1:0] s_arid,
    output logic [NUM_REQ-1:0]              s_rvalid,
    input  logic [NUM_REQ-1:0]              s_rready,
    output logic [DATA_W-1:0]               s_rdata,
    output logic                            s_rlast,
    output logic [1:0]                      s_rresp,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_W-1:0]               m_araddr,
    output logic [3:0]                      m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [1:0]                      m_arburst,
    output logic [ID_W-1:0]                 m_arid,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [DATA_W-1:0]               m_rdata,
    input  logic                            m_rlast,
    input  logic [1:0]                      m_rresp,
    input  logic [ID_W-1:0]                 m_rid,
    output logic                            busy,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            proto_err
);

    localparam int LID_W = ID_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [3:0]       beat_cnt;

    logic [ADDR_W-1:0] req_addr [NUM_REQ];
    logic [3:0]        req_len  [NUM_REQ];
    logic [LID_W-1:0]  req_id   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i] = s_araddr[i*ADDR_W +: ADDR_W];
        assign req_len[i]  = s_arlen[i*4 +: 4];
        assign req_id[i]   = s_arid[i*LID_W +: LID_W];
    end

    // Scan starts one past the previous winner so every requester gets a turn.
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        cand      = 0;
        cand_idx  = '0;
        sel_found = 1'b0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!sel_found && s_arvalid[cand_idx]) begin
                sel_found = 1'b1;
                sel       = cand_idx;
            end
        end
    end

    always_comb begin
        s_arready = '0;
        if (RST_N && state == IDLE && sel_found) begin
            s_arready[sel] = 1'b1;
        end
    end

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        if (RST_N && state == DATA) begin
            s_rvalid[grant_idx] = m_rvalid;
            m_rready            = s_rready[grant_idx];
        end
    end

    assign s_rdata   = m_rdata;
    assign s_rlast   = m_rlast;
    assign s_rresp   = m_rresp;
    assign m_arsize  = 3'b011;
    assign m_arburst = 2'b01;
    assign busy      = (state != IDLE);

    logic beat;
    logic beat_err;

    assign beat = m_rvalid && m_rready;

    // A last beat must land exactly on arlen, and no earlier beat may reach it.
    assign beat_err = (m_rid != m_arid) ||
                      (m_rlast ? (beat_cnt != m_arlen) : (beat_cnt == m_arlen));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arid     <= '0;
            beat_cnt   <= '0;
            proto_err  <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        m_araddr  <= req_addr[sel];
                        m_arlen   <= req_len[sel];
                        m_arid    <= {sel, req_id[sel]};
                        grant_idx <= sel;
                        beat_cnt  <= '0;
                        m_arvalid <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_err) begin
                            proto_err <= 1'b1;
                        end
                        if (m_rlast) begin
                            last_grant <= grant_idx;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: grant-order table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_axi_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int IDX_W   = 1;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 6;
    localparam int LID_W   = ID_W - IDX_W;

    logic                       CLK = 1'b0;
    logic                       RST_N;
    logic [NUM_REQ-1:0]         s_arvalid;
    logic [NUM_REQ-1:0]         s_arready;
    logic [NUM_REQ*ADDR_W-1:0]  s_araddr;
    logic [NUM_REQ*4-1:0]       s_arlen;
    logic [NUM_REQ*LID_W-1:0]   s_arid;
    logic [NUM_REQ-1:0]         s_rvalid;
    logic [NUM_REQ-1:0]         s_rready;
    logic [DATA_W-1:0]          s_rdata;
    logic                       s_rlast;
    logic [1:0]                 s_rresp;
    logic                       m_arvalid;
    logic                       m_arready;
    logic [ADDR_W-1:0]          m_araddr;
    logic [3:0]                 m_arlen;
    logic [2:0]                 m_arsize;
    logic [1:0]                 m_arburst;
    logic [ID_W-1:0]            m_arid;
    logic                       m_rvalid;
    logic                       m_rready;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_rlast;
    logic [1:0]                 m_rresp;
    logic [ID_W-1:0]            m_rid;
    logic                       busy;
    logic [IDX_W-1:0]           grant_idx;
    logic                       proto_err;

    axi_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rid(m_rid),
        .busy(busy), .grant_idx(grant_idx), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: who won last, and whether an anomaly has been seen.
    int   last_g  = NUM_REQ - 1;
    bit   exp_err = 1'b0;
    logic [ADDR_W-1:0] r_addr [NUM_REQ];
    logic [3:0]        r_len  [NUM_REQ];
    logic [LID_W-1:0]  r_id   [NUM_REQ];

    typedef struct {
        logic [NUM_REQ-1:0] arvalid;
        int                 exp_g;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ID_W-1:0] exp_id(input int g);
        return ID_W'((g << LID_W) | int'(r_id[g]));
    endfunction

    function automatic int pick_winner();
        int w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (last_g + k) % NUM_REQ;
            if (w < 0 && s_arvalid[c]) w = c;
        end
        return w;
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [3:0] l, input logic [4:0] id);
        r_addr[r] = a;
        r_len[r]  = l;
        r_id[r]   = id;
        s_araddr[r*ADDR_W +: ADDR_W] = a;
        s_arlen[r*4 +: 4]            = l;
        s_arid[r*LID_W +: LID_W]     = id;
        s_arvalid[r]                 = 1'b1;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        s_arvalid = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_rready  = '0;
        repeat (2) tick();
        RST_N   = 1'b1;
        exp_err = 1'b0;
        last_g  = NUM_REQ - 1;
    endtask

    // Called while IDLE with requests presented; the grant is taken on the next edge.
    task automatic grant(input int g);
        #1;
        chk("s_arready_grant", s_arready, 64'(1 << g));
        chk("idle_busy", busy, 0);
        tick();
        s_arvalid[g] = 1'b0;
    endtask

    task automatic ar_phase(input int g, input int delay);
        for (int d = 0; d <= delay; d++) begin
            m_arready = (d == delay);
            #1;
            chk("m_arvalid", m_arvalid, 1);
            chk("m_araddr", m_araddr, r_addr[g]);
            chk("m_arlen", m_arlen, r_len[g]);
            chk("m_arid", m_arid, exp_id(g));
            chk("m_arsize", m_arsize, 3);
            chk("m_arburst", m_arburst, 1);
            chk("grant_idx", grant_idx, g);
            chk("ar_s_arready", s_arready, 0);
            chk("ar_busy", busy, 1);
            tick();
        end
        m_arready = 1'b0;
    endtask

    // mode 0: always ready, 1: s_rready toggles every cycle, 2: random valid/ready.
    task automatic r_phase(input int g, input int nbeats, input logic [ID_W-1:0] rid, input int mode);
        int   b   = 0;
        int   cyc = 0;
        bit   tgl = 1'b0;
        logic [DATA_W-1:0] d;
        while (b < nbeats && cyc < 300) begin
            m_rvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            d        = {$urandom, $urandom};
            m_rdata  = d;
            m_rresp  = 2'($urandom);
            m_rid    = rid;
            m_rlast  = (b == nbeats - 1);
            s_rready = NUM_REQ'($urandom);
            if (mode == 0)      s_rready[g] = 1'b1;
            else if (mode == 1) begin s_rready[g] = tgl; tgl = !tgl; end
            else                s_rready[g] = ($urandom_range(0, 2) != 0);
            #1;
            chk("s_rvalid", s_rvalid, m_rvalid ? 64'(1 << g) : 64'd0);
            chk("m_rready", m_rready, s_rready[g]);
            chk("s_rdata", s_rdata, d);
            chk("s_rlast", s_rlast, m_rlast);
            chk("s_rresp", s_rresp, m_rresp);
            chk("dat_s_arready", s_arready, 0);
            if (m_rvalid && s_rready[g]) b++;
            cyc++;
            tick();
        end
        if (b < nbeats) chk("r_beat_timeout", b, nbeats);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        if (nbeats != int'(r_len[g]) + 1 || rid != exp_id(g)) exp_err = 1'b1;
        last_g = g;
        #1;
        chk("busy_after_last", busy, 0);
        chk("proto_err", proto_err, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b11, 0};
        tbl[1] = '{2'b11, 1};
        tbl[2] = '{2'b01, 0};
        tbl[3] = '{2'b01, 0};
        tbl[4] = '{2'b11, 1};
        tbl[5] = '{2'b10, 1};
        tbl[6] = '{2'b11, 0};
        tbl[7] = '{2'b10, 1};

        s_araddr = '0; s_arlen = '0; s_arid = '0;
        m_rdata = '0; m_rresp = '0; m_rid = '0;
        for (int r = 0; r < NUM_REQ; r++) begin r_addr[r] = '0; r_len[r] = '0; r_id[r] = '0; end

        // Reset values, observed while reset is held.
        do_reset();
        RST_N = 1'b0;
        s_rready = '1;
        tick();
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_m_arid", m_arid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_s_arready", s_arready, 0);
        s_rready = '0;
        RST_N = 1'b1;

        // Single request.
        set_req(0, 32'h1000_0000, 4'd3, 5'd5);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 4, 6'h05, 0);

        // Grant order table, starting from reset priority.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < NUM_REQ; r++)
                if (tbl[i].arvalid[r]) set_req(r, 32'h5000_0000 + 32'(i * 64 + r * 8), 4'd0, 5'(i + r));
            grant(tbl[i].exp_g);
            s_arvalid = '0;
            ar_phase(tbl[i].exp_g, 0);
            r_phase(tbl[i].exp_g, 1, exp_id(tbl[i].exp_g), 0);
        end

        // Loser keeps requesting; winner re-requests right away but must wait its turn.
        do_reset();
        set_req(0, 32'h6000_0000, 4'd0, 5'd1);
        set_req(1, 32'h6100_0000, 4'd0, 5'd2);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 1, exp_id(0), 0);
        set_req(0, 32'h6200_0000, 4'd0, 5'd3);
        grant(1);
        ar_phase(1, 0);
        r_phase(1, 1, exp_id(1), 0);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 1, exp_id(0), 0);

        // AR backpressure for five cycles.
        set_req(1, 32'h2000_0040, 4'd5, 5'd3);
        grant(1);
        ar_phase(1, 5);
        r_phase(1, 6, exp_id(1), 0);

        // R backpressure with s_rready toggling.
        set_req(1, 32'h2000_1000, 4'd7, 5'd4);
        grant(1);
        ar_phase(1, 0);
        r_phase(1, 8, exp_id(1), 1);

        // Early rlast.
        do_reset();
        set_req(0, 32'h4000_0000, 4'd3, 5'd5);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 3, 6'h05, 0);

        // RID mismatch, then stickiness across a clean burst.
        do_reset();
        #1;
        chk("err_cleared_by_reset", proto_err, 0);
        set_req(0, 32'h4100_0000, 4'd3, 5'd5);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 4, 6'h3F, 0);
        set_req(1, 32'h4200_0000, 4'd2, 5'd9);
        grant(1);
        ar_phase(1, 0);
        r_phase(1, 3, exp_id(1), 0);

        // Reset during beat 2 of a long burst from requester 1.
        do_reset();
        set_req(0, 32'h3000_0000, 4'd0, 5'd1);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 1, exp_id(0), 0);
        set_req(1, 32'h3100_0000, 4'd7, 5'd2);
        grant(1);
        ar_phase(1, 0);
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1; m_rlast = 1'b0; m_rid = exp_id(1); s_rready = 2'b10;
            tick();
        end
        RST_N = 1'b0;
        tick();
        RST_N   = 1'b1;
        exp_err = 1'b0;
        last_g  = NUM_REQ - 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m_arvalid", m_arvalid, 0);
        chk("mid_rst_m_rready", m_rready, 0);
        chk("mid_rst_s_rvalid", s_rvalid, 0);
        chk("mid_rst_grant_idx", grant_idx, 0);
        m_rvalid = 1'b0;
        s_rready = '0;
        set_req(0, 32'h3200_0000, 4'd1, 5'd7);
        set_req(1, 32'h3300_0000, 4'd0, 5'd8);
        grant(0);
        ar_phase(0, 0);
        r_phase(0, 2, exp_id(0), 0);
        grant(1);
        ar_phase(1, 0);
        r_phase(1, 1, exp_id(1), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int rnd = 0; rnd < 150; rnd++) begin
            int w;
            int nb;
            logic [ID_W-1:0] rid;
            for (int r = 0; r < NUM_REQ; r++)
                if (!s_arvalid[r] && $urandom_range(0, 1) == 1)
                    set_req(r, $urandom, 4'($urandom), 5'($urandom));
            if (s_arvalid == '0) begin
                int r = $urandom_range(0, NUM_REQ - 1);
                set_req(r, $urandom, 4'($urandom), 5'($urandom));
            end
            w = pick_winner();
            grant(w);
            ar_phase(w, $urandom_range(0, 3));
            nb  = int'(r_len[w]) + 1;
            rid = exp_id(w);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 0) rid = rid ^ 6'h01;
                else nb = (nb == 1) ? 2 : nb - 1;
            end
            r_phase(w, nb, rid, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
